mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_tag_pipe.sv | 35 +++
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port ids, in-flight tags
// and the default memory read latency.
package mem_arb_pkg;

  localparam int MEM_LAT_DEFAULT = 2;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, port: PORT_IF};

  // kill[0] drops port 0 tags, kill[1] drops port 1 tags.
  function automatic tag_t kill_tag(tag_t t, logic [1:0] kill);
    tag_t r;
    r = t;
    if ((t.port == PORT_LD) ? kill[1] : kill[0]) r.valid = 1'b0;
    return r;
  endfunction

  function automatic port_e other_port(port_e p);
    return (p == PORT_IF) ? PORT_LD : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Fixed-depth shift pipeline of read tags; the last stage names the port that
// owns the memory data in the current cycle.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_valid,
  input  port_e      push_port,
  input  logic [1:0] kill,
  output tag_t       pop_tag
);

  tag_t stage_q [DEPTH];
  tag_t push_tag;

  assign push_tag = '{valid: push_valid, port: push_port};

  // The tag leaving the last stage is already being delivered, so a kill only
  // applies to tags that still have at least one stage to travel (and the one
  // entering now).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_EMPTY;
    end else begin
      stage_q[0] <= kill_tag(push_tag, kill);
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= kill_tag(stage_q[i-1], kill);
    end
  end

  assign pop_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency read memory between the
// instruction-fetch port (0) and the data-load port (1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  input  logic          flush,
  output logic          mem_read_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_q
);

  port_e ptr_q;
  port_e winner;
  logic  gnt_any;
  tag_t  pop_tag;

  // ptr_q names the port that wins when both request.
  always_comb begin
    winner  = PORT_IF;
    gnt_any = 1'b0;
    if (rst_n) begin
      gnt_any = if_req | ld_req;
      if (if_req && ld_req) winner = ptr_q;
      else if (ld_req)      winner = PORT_LD;
      else                  winner = PORT_IF;
    end
  end

  always_comb begin
    if_gnt      = 1'b0;
    ld_gnt      = 1'b0;
    mem_read_en = 1'b0;
    mem_addr    = '0;
    if (gnt_any) begin
      mem_read_en = 1'b1;
      if (winner == PORT_LD) begin
        ld_gnt   = 1'b1;
        mem_addr = ld_addr;
      end else begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       ptr_q <= PORT_LD;
    else if (gnt_any) ptr_q <= other_port(winner);
  end

  mem_arb_tag_pipe #(
    .DEPTH(MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(gnt_any),
    .push_port (winner),
    .kill      ({1'b0, flush}),
    .pop_tag   (pop_tag)
  );

  // Gated by rst_n so nothing leaks out during the cycle reset is first seen.
  always_comb begin
    if_rvalid = rst_n & pop_tag.valid & (pop_tag.port == PORT_IF);
    ld_rvalid = rst_n & pop_tag.valid & (pop_tag.port == PORT_LD);
    if_rdata  = if_rvalid ? mem_q : '0;
    ld_rdata  = ld_rvalid ? mem_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two builds (MEM_LAT 2 and 3) share the stimulus;
// a schedule-based model checks every cycle, directed pins anchor the model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ld_req = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, ld_addr = '0;
  logic [31:0] mem_q;

  logic        a_if_gnt, a_if_rvalid, a_ld_gnt, a_ld_rvalid, a_mre;
  logic [31:0] a_if_rdata, a_ld_rdata, a_maddr;
  logic        b_if_gnt, b_if_rvalid, b_ld_gnt, b_ld_rvalid, b_mre;
  logic [31:0] b_if_rdata, b_ld_rdata, b_maddr;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expected response schedule per build, indexed by due cycle.
  bit due_if [2][1024];
  bit due_ld [2][1024];
  bit last_ld [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memq_of(int c);
    return 32'hA500_0000 + 32'(c) * 32'd3;
  endfunction

  assign mem_q = memq_of(cyc);

  mem_port_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(a_ld_gnt),
    .ld_rvalid(a_ld_rvalid), .ld_rdata(a_ld_rdata),
    .flush(flush), .mem_read_en(a_mre), .mem_addr(a_maddr), .mem_q(mem_q)
  );

  mem_port_arbiter #(.MEM_LAT(3), .AW(32), .DW(32)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(b_ld_gnt),
    .ld_rvalid(b_ld_rvalid), .ld_rdata(b_ld_rdata),
    .flush(flush), .mem_read_en(b_mre), .mem_addr(b_maddr), .mem_q(mem_q)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Model: grants from the round-robin rule; a grant in cycle c is due at c+lat;
  // flush in f cancels port 0 responses due in f+1..f+lat; reset in r cancels
  // everything due in r..r+lat.
  task automatic model_cycle(input int k, input int lat,
                             input logic ig, input logic lg, input logic mre,
                             input logic [31:0] maddr,
                             input logic irv, input logic lrv,
                             input logic [31:0] ird, input logic [31:0] lrd);
    int c;
    logic eg_if, eg_ld, e_irv, e_lrv;
    logic [31:0] e_addr;
    c = cyc;
    eg_if = 1'b0;
    eg_ld = 1'b0;
    if (rst_n) begin
      if (if_req && ld_req) begin
        if (last_ld[k]) eg_if = 1'b1;
        else            eg_ld = 1'b1;
      end else begin
        eg_if = if_req;
        eg_ld = ld_req;
      end
    end
    e_addr = eg_if ? if_addr : (eg_ld ? ld_addr : 32'h0);
    e_irv  = rst_n && due_if[k][c];
    e_lrv  = rst_n && due_ld[k][c];
    chk($sformatf("m%0d_if_gnt", k), 64'(ig), 64'(eg_if));
    chk($sformatf("m%0d_ld_gnt", k), 64'(lg), 64'(eg_ld));
    chk($sformatf("m%0d_mem_read_en", k), 64'(mre), 64'(eg_if | eg_ld));
    chk($sformatf("m%0d_mem_addr", k), 64'(maddr), 64'(e_addr));
    chk($sformatf("m%0d_if_rvalid", k), 64'(irv), 64'(e_irv));
    chk($sformatf("m%0d_ld_rvalid", k), 64'(lrv), 64'(e_lrv));
    chk($sformatf("m%0d_if_rdata", k), 64'(ird), e_irv ? 64'(mem_q) : 64'h0);
    chk($sformatf("m%0d_ld_rdata", k), 64'(lrd), e_lrv ? 64'(mem_q) : 64'h0);
    if (!rst_n) begin
      last_ld[k] = 1'b0;
      for (int d = 0; d <= lat; d++) begin
        due_if[k][c+d] = 1'b0;
        due_ld[k][c+d] = 1'b0;
      end
    end else begin
      if (eg_if) begin due_if[k][c+lat] = 1'b1; last_ld[k] = 1'b0; end
      if (eg_ld) begin due_ld[k][c+lat] = 1'b1; last_ld[k] = 1'b1; end
      if (flush) for (int d = 1; d <= lat; d++) due_if[k][c+d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (cyc < 1000) begin
      model_cycle(0, 2, a_if_gnt, a_ld_gnt, a_mre, a_maddr,
                  a_if_rvalid, a_ld_rvalid, a_if_rdata, a_ld_rdata);
      model_cycle(1, 3, b_if_gnt, b_ld_gnt, b_mre, b_maddr,
                  b_if_rvalid, b_ld_rvalid, b_if_rdata, b_ld_rdata);
    end
  end

  // Drives one cycle's inputs just after the edge, returns at mid-cycle.
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic lr, input logic [31:0] la,
                      input logic fl, input logic rs);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la; flush = fl; rst_n = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset with requests pending: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h8, 1'b1, 32'hC, 1'b0, 1'b0);
      chk("rst_mem_read_en", 64'(a_mre), 64'h0);
      chk("rst_gnt", 64'({a_if_gnt, a_ld_gnt}), 64'h0);
    end

    // Both ports held for six cycles: LD first, strict alternation, no gaps.
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(1'b1, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1);
      else       idle(1);
      if (i < 6) begin
        chk("alt_gnt", 64'({a_if_gnt, a_ld_gnt}), (i % 2 == 0) ? 64'h1 : 64'h2);
        chk("alt_mem_read_en", 64'(a_mre), 64'h1);
        chk("alt_mem_addr", 64'(a_maddr), (i % 2 == 0) ? 64'h40 : 64'h0);
      end
      if (i >= 2)
        chk("alt_rvalid", 64'({a_if_rvalid, a_ld_rvalid}), (i % 2 == 0) ? 64'h1 : 64'h2);
    end
    idle(2);

    // IF at cycles 0,1 killed by flush in 1; IF granted in 2 returns in 4.
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("fl_gnt0", 64'(a_if_gnt), 64'h1);
    step(1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("fl_gnt2", 64'(a_if_gnt), 64'h1);
    chk("fl_rv2", 64'(a_if_rvalid), 64'h0);
    idle(1);
    chk("fl_rv3", 64'(a_if_rvalid), 64'h0);
    idle(1);
    chk("fl_rv4", 64'(a_if_rvalid), 64'h1);
    chk("fl_rdata4", 64'(a_if_rdata), 64'(memq_of(cyc)));
    idle(2);

    // LD at 0, IF at 1 with flush: load survives, fetch is dropped.
    step(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b1);
    chk("mix_ld_gnt", 64'(a_ld_gnt), 64'h1);
    step(1'b1, 32'h204, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("mix_if_gnt", 64'(a_if_gnt), 64'h1);
    idle(1);
    chk("mix_ld_rv", 64'(a_ld_rvalid), 64'h1);
    idle(1);
    chk("mix_if_rv", 64'(a_if_rvalid), 64'h0);
    idle(2);

    // Reset in cycle 2 discards the two in-flight reads; pointer back to LD.
    step(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b1);
    step(1'b1, 32'h304, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h308, 1'b1, 32'h30C, 1'b0, 1'b0);
    chk("rr_gnt_in_reset", 64'(a_mre), 64'h0);
    chk("rr_rv2", 64'({a_if_rvalid, a_ld_rvalid}), 64'h0);
    for (int i = 3; i <= 5; i++) begin
      idle(1);
      chk("rr_rv", 64'({a_if_rvalid, a_ld_rvalid, b_if_rvalid, b_ld_rvalid}), 64'h0);
    end
    step(1'b1, 32'h310, 1'b1, 32'h314, 1'b0, 1'b1);
    chk("rr_ptr_ld", 64'({a_if_gnt, a_ld_gnt}), 64'h1);
    step(1'b1, 32'h310, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rr_if_next", 64'(a_if_gnt), 64'h1);
    idle(3);

    // Single LD read at 0x10.
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b1);
    chk("ld1_gnt", 64'({a_if_gnt, a_ld_gnt}), 64'h1);
    chk("ld1_addr", 64'(a_maddr), 64'h10);
    idle(1);
    chk("ld1_rv1", 64'({a_if_rvalid, a_ld_rvalid}), 64'h0);
    idle(1);
    chk("ld1_rv2", 64'({a_if_rvalid, a_ld_rvalid}), 64'h1);
    chk("ld1_rdata", 64'(a_ld_rdata), 64'(memq_of(cyc)));
    idle(2);

    // Three back-to-back fetches on the MEM_LAT=3 build.
    for (int i = 0; i < 7; i++) begin
      if (i < 3) step(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b1);
      else       idle(1);
      if (i < 3) chk("l3_addr", 64'(b_maddr), 64'(i * 4));
      chk("l3_if_rv", 64'(b_if_rvalid), (i >= 3 && i <= 5) ? 64'h1 : 64'h0);
      if (i >= 3 && i <= 5) chk("l3_if_rdata", 64'(b_if_rdata), 64'(memq_of(cyc)));
    end

    // Mixed pattern with flushes and a reset pulse, checked by the model only.
    for (int i = 0; i < 48; i++)
      step((i % 3) != 0, 32'h1000 + 32'(i * 4), (i % 2) == 0, 32'h2000 + 32'(i * 8),
           (i % 7) == 3, i != 30);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
